// File: rtl/reset_button_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : reset_button_pkg                                                |
// | Brief    : Shared types and default tick constants for the reset decoder.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package reset_button_pkg;

  localparam int unsigned TIMER_W = 32;
  localparam int unsigned TAPS_W  = 4;

  // Default tick counts for a 50 MHz system clock
  localparam int unsigned c_debounce_ticks_50m = 500_000;
  localparam int unsigned c_long_press_ticks_50m = 50_000_000;
  localparam int unsigned c_gap_ticks_50m = 25_000_000;
  localparam int unsigned c_max_taps_default = 15;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_GAP       = 2'd2,
    ST_HOLD_WAIT = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/button_debouncer.sv
// +----------------------------------------------------------------------------+
// | Module   : button_debouncer                                                |
// | Brief    : 2-flop synchronizer plus stable-count debouncer, active-high out |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module button_debouncer
  import reset_button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = c_debounce_ticks_50m
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed
);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_pressed;
  logic [TIMER_W-1:0] r_cnt;
  logic               w_sync_pressed;

  localparam logic [TIMER_W-1:0] c_last_tick = DEBOUNCE_TICKS - 1;

  assign w_sync_pressed = ~r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_pressed <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
      // Any cycle agreeing with the current level restarts the stability window
      if (w_sync_pressed == r_pressed) begin
        r_cnt <= '0;
      end else if (r_cnt == c_last_tick) begin
        r_pressed <= w_sync_pressed;
        r_cnt     <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign pressed = r_pressed;

endmodule

`default_nettype wire

// File: rtl/reset_button_decoder.sv
// +----------------------------------------------------------------------------+
// | Module   : reset_button_decoder                                            |
// | Brief    : Classifies reset-button gestures into N-tap or long-hold events. |
// |            Optional macro RESET_BUTTON_PASSTHROUGH_EN forwards first press. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module reset_button_decoder
  import reset_button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS   = c_debounce_ticks_50m,
  parameter int unsigned LONG_PRESS_TICKS = c_long_press_ticks_50m,
  parameter int unsigned GAP_TICKS        = c_gap_ticks_50m,
  parameter int unsigned MAX_TAPS         = c_max_taps_default
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_n,
  output logic              evt_valid,
  output logic              evt_long,
  output logic [TAPS_W-1:0] evt_taps,
  output logic              busy,
  output logic              rst_out
);

  localparam logic [TIMER_W-1:0] c_long_last = LONG_PRESS_TICKS - 1;
  localparam logic [TIMER_W-1:0] c_gap_last  = GAP_TICKS - 1;
  localparam logic [TIMER_W-1:0] c_max_taps_w = MAX_TAPS;
  localparam logic [TAPS_W-1:0]  c_max_taps  = c_max_taps_w[TAPS_W-1:0];

  logic               w_pressed;
  state_t             r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [TAPS_W-1:0]  r_taps;
  logic               r_evt_valid;
  logic               r_evt_long;
  logic [TAPS_W-1:0]  r_evt_taps;

  button_debouncer #(
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_debouncer (
    .clk     (clk),
    .rst     (rst),
    .btn_n   (btn_n),
    .pressed (w_pressed)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_taps      <= '0;
      r_evt_valid <= 1'b0;
      r_evt_long  <= 1'b0;
      r_evt_taps  <= '0;
    end else begin
      r_evt_valid <= 1'b0;
      if (r_timer != '1) begin
        r_timer <= r_timer + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_pressed) begin
            r_state <= ST_PRESSED;
            r_timer <= '0;
          end
        end
        ST_PRESSED: begin
          // Threshold is checked first so a simultaneous release still counts as long
          if (r_timer == c_long_last) begin
            r_evt_valid <= 1'b1;
            r_evt_long  <= 1'b1;
            r_evt_taps  <= r_taps;
            r_state     <= ST_HOLD_WAIT;
            r_timer     <= '0;
          end else if (!w_pressed) begin
            if (r_taps != c_max_taps) begin
              r_taps <= r_taps + 1'b1;
            end
            r_state <= ST_GAP;
            r_timer <= '0;
          end
        end
        ST_GAP: begin
          if (r_timer == c_gap_last) begin
            r_evt_valid <= 1'b1;
            r_evt_long  <= 1'b0;
            r_evt_taps  <= r_taps;
            r_taps      <= '0;
            r_state     <= ST_IDLE;
            r_timer     <= '0;
          end else if (w_pressed) begin
            r_state <= ST_PRESSED;
            r_timer <= '0;
          end
        end
        ST_HOLD_WAIT: begin
          if (!w_pressed) begin
            r_taps  <= '0;
            r_state <= ST_IDLE;
            r_timer <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_long  = r_evt_long;
  assign evt_taps  = r_evt_taps;
  assign busy      = (r_state != ST_IDLE);

`ifdef RESET_BUTTON_PASSTHROUGH_EN
  // Only the first press of a gesture reaches the console as a native reset
  assign rst_out = w_pressed && (r_state == ST_PRESSED) && (r_taps == '0);
`else
  assign rst_out = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reset_button_decoder.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_reset_button_decoder                                         |
// | Brief    : Directed self-checking bench for reset_button_decoder.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_reset_button_decoder;

  localparam int unsigned D = 4;
  localparam int unsigned L = 40;
  localparam int unsigned G = 20;

`ifdef RESET_BUTTON_PASSTHROUGH_EN
  localparam logic c_pt = 1'b1;
`else
  localparam logic c_pt = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_n;
  logic       evt_valid;
  logic       evt_long;
  logic [3:0] evt_taps;
  logic       busy;
  logic       rst_out;

  int n_checks = 0;
  int n_errors = 0;

  reset_button_decoder #(
    .DEBOUNCE_TICKS   (D),
    .LONG_PRESS_TICKS (L),
    .GAP_TICKS        (G),
    .MAX_TAPS         (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_n),
    .evt_valid (evt_valid),
    .evt_long  (evt_long),
    .evt_taps  (evt_taps),
    .busy      (busy),
    .rst_out   (rst_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: cyc equals the number of the edge that raised the strobe
  int         n_evt = 0;
  int         n_wide = 0;
  int         evt_cyc = -1;
  logic       last_long = 1'b0;
  logic [3:0] last_taps = '0;
  logic       evt_busy = 1'b0;
  logic       prev_v = 1'b0;
  always @(posedge clk) begin
    #1;
    if (evt_valid) begin
      n_evt++;
      evt_cyc   = cyc;
      last_long = evt_long;
      last_taps = evt_taps;
      evt_busy  = busy;
      if (prev_v) n_wide++;
    end
    prev_v = evt_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press for len cycles then release; returns the release cycle
  task automatic tap(input int len, output int rel);
    btn_n = 1'b0;
    wait_cyc(len);
    rel = cyc;
    btn_n = 1'b1;
  endtask

  initial begin
    int base;
    int r;
    int p;
    logic bflag;

    rst   = 1'b1;
    btn_n = 1'b1;
    #1;
    check("reset_evt_valid", evt_valid, 0);
    check("reset_evt_long", evt_long, 0);
    check("reset_evt_taps", evt_taps, 0);
    check("reset_busy", busy, 0);
    check("reset_rst_out", rst_out, 0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(10);

    // Single tap
    base = n_evt;
    btn_n = 1'b0;
    wait_cyc(9);
    check("t1_rst_out_first_press", rst_out, c_pt);
    wait_cyc(6);
    r = cyc;
    btn_n = 1'b1;
    wait_cyc(10);
    check("t1_busy_in_gap", busy, 1);
    wait_cyc(30);
    check("t1_evt_count", n_evt - base, 1);
    check("t1_evt_cyc", evt_cyc, r + 3 + D + G);
    check("t1_evt_long", last_long, 0);
    check("t1_evt_taps", last_taps, 1);
    check("t1_busy_at_evt", evt_busy, 0);
    check("t1_busy_after", busy, 0);

    // Triple tap
    base = n_evt;
    for (int i = 0; i < 3; i++) begin
      btn_n = 1'b0;
      wait_cyc(9);
      if (i == 1) check("t2_rst_out_second_tap", rst_out, 0);
      wait_cyc(1);
      r = cyc;
      btn_n = 1'b1;
      if (i < 2) wait_cyc(8);
    end
    wait_cyc(40);
    check("t2_evt_count", n_evt - base, 1);
    check("t2_evt_cyc", evt_cyc, r + 3 + D + G);
    check("t2_evt_long", last_long, 0);
    check("t2_evt_taps", last_taps, 3);

    // Tap followed by a long hold
    base = n_evt;
    tap(10, r);
    wait_cyc(8);
    p = cyc;
    btn_n = 1'b0;
    wait_cyc(100);
    check("t3_evt_count", n_evt - base, 1);
    check("t3_evt_cyc", evt_cyc, p + 3 + D + L);
    check("t3_evt_long", last_long, 1);
    check("t3_evt_taps", last_taps, 1);
    check("t3_busy_holding", busy, 1);
    check("t3_rst_out_hold", rst_out, 0);
    btn_n = 1'b1;
    wait_cyc(40);
    check("t3_evt_count_after", n_evt - base, 1);
    check("t3_busy_after", busy, 0);

    // Bounce rejection
    base = n_evt;
    bflag = 1'b0;
    repeat (5) begin
      btn_n = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (busy) bflag = 1'b1;
      end
      btn_n = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (busy) bflag = 1'b1;
      end
    end
    wait_cyc(30);
    check("t4_evt_count", n_evt - base, 0);
    check("t4_busy_seen", bflag, 0);

    // Tap count saturation
    base = n_evt;
    for (int i = 0; i < 17; i++) begin
      tap(10, r);
      if (i < 16) wait_cyc(8);
    end
    wait_cyc(40);
    check("t5_evt_count", n_evt - base, 1);
    check("t5_evt_taps", last_taps, 15);
    check("t5_evt_long", last_long, 0);

    // Asynchronous reset in the middle of a press
    base = n_evt;
    btn_n = 1'b0;
    wait_cyc(20);
    check("t6_busy_before_rst", busy, 1);
    check("t6_rst_out_before_rst", rst_out, c_pt);
    #2;
    rst = 1'b1;
    #1;
    check("t6_busy_in_rst", busy, 0);
    check("t6_evt_valid_in_rst", evt_valid, 0);
    check("t6_rst_out_in_rst", rst_out, 0);
    @(negedge clk);
    btn_n = 1'b1;
    wait_cyc(4);
    rst = 1'b0;
    wait_cyc(40);
    check("t6_no_evt", n_evt - base, 0);
    check("t6_busy_idle", busy, 0);
    tap(15, r);
    wait_cyc(40);
    check("t6_fresh_count", n_evt - base, 1);
    check("t6_fresh_cyc", evt_cyc, r + 3 + D + G);
    check("t6_fresh_taps", last_taps, 1);
    check("t6_fresh_long", last_long, 0);

    check("strobe_single_cycle", n_wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
